// File: rtl/teng_harvest_ctrl.sv
// TENG cell sequencer: arm on |Vteng|, track the peak, harvest through the switch,
// then pulse the cell charge-reset. A one-cycle GAP state keeps sw_harv and en apart.
module teng_harvest_ctrl #(
  parameter int ADC_W     = 12,
  parameter int V_MIN     = 200,
  parameter int PEAK_DROP = 16,
  parameter int V_END     = 32,
  parameter int HARV_MAX  = 64,
  parameter int RST_CYC   = 8,
  parameter int TMO       = 1024,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             adc_vld,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             clr_flag,
  output logic             adc_req,
  output logic             sw_harv,
  output logic             en,
  output logic             busy,
  output logic [CNT_W-1:0] harv_cnt,
  output logic [ADC_W-1:0] peak_val,
  output logic             tmo_flag
);
  localparam int TW = $clog2(TMO + 1);
  localparam int HW = $clog2(HARV_MAX + 1);
  localparam int RW = $clog2(RST_CYC + 1);

  localparam logic [ADC_W-1:0] VMIN_C = ADC_W'(V_MIN);
  localparam logic [ADC_W-1:0] DROP_C = ADC_W'(PEAK_DROP);
  localparam logic [ADC_W-1:0] VEND_C = ADC_W'(V_END);
  localparam logic [ADC_W-1:0] NEG_FS = {1'b1, {(ADC_W-1){1'b0}}};
  localparam logic [ADC_W-1:0] POS_FS = {1'b0, {(ADC_W-1){1'b1}}};
  localparam logic [ADC_W-1:0] ONE_C  = {{(ADC_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_TRACK, S_HARV, S_GAP, S_RESET} state_t;

  state_t           state, state_nx;
  logic [ADC_W-1:0] mag, peak;
  logic [TW-1:0]    timer;
  logic [HW-1:0]    hcnt;
  logic [RW-1:0]    rcnt;
  logic             acc, peak_exit, tmo_exit, harv_done;

  assign acc = adc_req & adc_vld;

  // Most-negative code has no positive twin; clamp it to full scale.
  always_comb begin
    if (!adc_data[ADC_W-1])    mag = adc_data;
    else if (adc_data == NEG_FS) mag = POS_FS;
    else                        mag = (~adc_data) + ONE_C;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    peak_exit = 1'b0;
    tmo_exit  = 1'b0;
    harv_done = 1'b0;
    case (state)
      S_IDLE:  if (enable_i) state_nx = S_ARM;
      S_ARM: begin
        if (!enable_i)                  state_nx = S_IDLE;
        else if (acc && mag >= VMIN_C)  state_nx = S_TRACK;
      end
      S_TRACK: begin
        if (!enable_i) state_nx = S_RESET;
        else if (acc && mag <= peak && (peak - mag) >= DROP_C) begin
          state_nx  = S_HARV;
          peak_exit = 1'b1;
        end else if (timer == TW'(TMO - 1)) begin
          state_nx = S_RESET;
          tmo_exit = 1'b1;
        end
      end
      S_HARV: begin
        if (!enable_i) state_nx = S_GAP;
        else if ((acc && mag <= VEND_C) || hcnt == HW'(HARV_MAX - 1)) begin
          state_nx  = S_GAP;
          harv_done = 1'b1;
        end
      end
      S_GAP:   state_nx = S_RESET;
      S_RESET: if (rcnt == RW'(RST_CYC - 1)) state_nx = enable_i ? S_ARM : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    adc_req = (state == S_ARM) || (state == S_TRACK) || (state == S_HARV);
    sw_harv = (state == S_HARV);
    en      = (state == S_RESET);
    busy    = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak     <= '0;
      peak_val <= '0;
      timer    <= '0;
      hcnt     <= '0;
      rcnt     <= '0;
      harv_cnt <= '0;
      tmo_flag <= 1'b0;
    end else begin
      timer <= (state == S_TRACK) ? timer + 1'b1 : '0;
      hcnt  <= (state == S_HARV)  ? hcnt + 1'b1  : '0;
      rcnt  <= (state == S_RESET) ? rcnt + 1'b1  : '0;
      if (state == S_ARM && state_nx == S_TRACK)               peak <= mag;
      else if (state == S_TRACK && enable_i && acc && mag > peak) peak <= mag;
      if (peak_exit) peak_val <= peak;
      if (harv_done && harv_cnt != '1) harv_cnt <= harv_cnt + 1'b1;
      if (tmo_exit)      tmo_flag <= 1'b1;
      else if (clr_flag) tmo_flag <= 1'b0;
    end
  end
endmodule

// File: tb/tb_teng_harvest_ctrl.sv
// Scoreboard bench: stimulus queues the expected output tuple (and how long the previous
// tuple must have lasted); a negedge monitor pops and compares on every output change.
module tb_teng_harvest_ctrl;
  logic        clk = 1'b0, rst, enable_i, adc_vld, clr_flag;
  logic [11:0] adc_data;
  logic        adc_req, sw_harv, en, busy, tmo_flag;
  logic [15:0] harv_cnt;
  logic [11:0] peak_val;

  teng_harvest_ctrl dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .adc_vld(adc_vld), .adc_data(adc_data),
    .clr_flag(clr_flag), .adc_req(adc_req), .sw_harv(sw_harv), .en(en), .busy(busy),
    .harv_cnt(harv_cnt), .peak_val(peak_val), .tmo_flag(tmo_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic req, sw, en, busy, tmo;
    logic [15:0] hc;
    logic [11:0] pv;
  } tup_t;

  typedef struct {
    string name;
    tup_t  t;
    int    len;   // cycles the previous tuple must have held; -1 = don't care
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0;
  bit   mon_on = 0, started = 0;
  tup_t last;
  int   run;

  function automatic tup_t mk(bit r, bit s, bit e, bit b, bit t, int hc, int pv);
    tup_t x;
    x.req = r; x.sw = s; x.en = e; x.busy = b; x.tmo = t;
    x.hc = 16'(hc); x.pv = 12'(pv);
    return x;
  endfunction

  task automatic push(string nm, tup_t t, int len);
    exp_t e;
    e.name = nm; e.t = t; e.len = len;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(int d);
    adc_data = 12'(d);
    adc_vld  = 1'b1;
    step();
  endtask

  always @(negedge clk) begin
    tup_t cur;
    exp_t e;
    cur = {adc_req, sw_harv, en, busy, tmo_flag, harv_cnt, peak_val};
    if (mon_on) begin
      if (!started) begin
        last = cur; run = 1; started = 1;
      end else if (cur !== last) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change: got %h after %0d cycles, none expected", cur, run);
        end else begin
          e = q.pop_front();
          if (cur !== e.t || (e.len >= 0 && run != e.len)) begin
            n_bad++;
            $display("FAIL %s: got %h held %0d, want %h held %0d", e.name, cur, run, e.t, e.len);
          end
        end
        if (sw_harv && en) begin
          n_bad++;
          $display("FAIL overlap: sw_harv and en both high");
        end
        last = cur; run = 1;
      end else run++;
    end
  end

  initial begin
    tup_t r0;
    rst = 1'b1; enable_i = 1'b1; adc_vld = 1'b0; adc_data = '0; clr_flag = 1'b0;
    step(); step();
    @(negedge clk);
    r0 = {adc_req, sw_harv, en, busy, tmo_flag, harv_cnt, peak_val};
    n_cmp++;
    if (r0 !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %h want 0", r0);
    end
    mon_on = 1;
    step();
    push("arm_after_rst", mk(1,0,0,1,0,0,0), -1);
    rst = 1'b0;
    step();

    // normal positive pulse; drop of 20 at 480 already crosses PEAK_DROP
    send(100); send(250); send(400); send(500); send(480);
    push("harv_pos", mk(1,1,0,1,0,0,500), 5);
    send(470); send(200); send(30);
    adc_vld = 1'b0;
    push("gap_pos", mk(0,0,0,1,0,1,500), 3);
    push("en_pos",  mk(0,0,1,1,0,1,500), 1);
    push("arm_pos", mk(1,0,0,1,0,1,500), 8);
    repeat (10) step();

    // negative polarity with saturated full-scale code
    send(-2048); send(-2040); send(-2000);
    push("harv_neg", mk(1,1,0,1,0,1,2047), -1);
    send(10);
    adc_vld = 1'b0;
    push("gap_neg", mk(0,0,0,1,0,2,2047), 1);
    push("en_neg",  mk(0,0,1,1,0,2,2047), 1);
    push("arm_neg", mk(1,0,0,1,0,2,2047), 8);
    repeat (9) step();

    // TRACK timeout: 1 ARM cycle + 1024 TRACK cycles before RESET
    send(300);
    adc_vld = 1'b0;
    push("tmo_reset", mk(0,0,1,1,1,2,2047), 1025);
    push("tmo_arm",   mk(1,0,0,1,1,2,2047), 8);
    repeat (1034) step();
    push("tmo_clear", mk(1,0,0,1,0,2,2047), 3);
    clr_flag = 1'b1;
    step();
    clr_flag = 1'b0;

    // harvest runs out at HARV_MAX cycles
    send(600); send(580);
    push("harv_max", mk(1,1,0,1,0,2,600), -1);
    repeat (64) send(500);
    adc_vld = 1'b0;
    push("gap_max", mk(0,0,0,1,0,3,600), 64);
    push("en_max",  mk(0,0,1,1,0,3,600), 1);
    push("arm_max", mk(1,0,0,1,0,3,600), 8);
    repeat (10) step();

    // enable drop during HARVEST: no count, full en pulse, then IDLE
    send(700); send(650);
    push("harv_en", mk(1,1,0,1,0,3,700), -1);
    send(640);
    adc_vld = 1'b0;
    enable_i = 1'b0;
    push("gap_en",  mk(0,0,0,1,0,3,700), 2);
    push("en_en",   mk(0,0,1,1,0,3,700), 1);
    push("idle_en", mk(0,0,0,0,0,3,700), 8);
    step();
    repeat (12) step();

    // rst during the en pulse
    enable_i = 1'b1;
    push("arm_re", mk(1,0,0,1,0,3,700), -1);
    step();
    send(300);
    adc_vld = 1'b0;
    enable_i = 1'b0;
    push("en_trk_drop", mk(0,0,1,1,0,3,700), 2);
    step(); step(); step();
    rst = 1'b1;
    push("rst_mid_en", mk(0,0,0,0,0,0,0), 3);
    step();
    rst = 1'b0;
    repeat (5) step();

    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events: %0d expected changes never seen, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
